// File: rtl/dec4_stream.sv
// Two-entry FIFO of priority-encoder words {v, code} with a one-hot decoder on the head
// entry and a saturating count of popped "no line active" words.
module dec4_stream (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [1:0] in_code,
   input  logic       in_v,
   output logic       in_ready,
   output logic       out_valid,
   output logic [3:0] out_onehot,
   input  logic       out_ready,
   output logic [1:0] level,
   output logic [7:0] none_cnt
);

   logic [2:0] mem_q [2];
   logic       wr_ptr_q, wr_ptr_d;
   logic       rd_ptr_q, rd_ptr_d;
   logic [1:0] level_q, level_d;
   logic [7:0] none_cnt_q, none_cnt_d;
   logic [2:0] head;
   logic       push, pop;

   // in_ready depends only on rst and registered level, never on out_ready
   assign in_ready  = !rst && (level_q != 2'd2);
   assign out_valid = (level_q != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign head      = mem_q[rd_ptr_q];

   always_comb begin
      out_onehot = '0;
      if (out_valid && head[2]) begin
         out_onehot = 4'b0001 << head[1:0];
      end
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      none_cnt_d = none_cnt_q;
      if (push) begin
         wr_ptr_d = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
         if (!head[2] && (none_cnt_q != 8'hFF)) begin
            none_cnt_d = none_cnt_q + 8'd1;
         end
      end
      case ({push, pop})
         2'b10:   level_d = level_q + 2'd1;
         2'b01:   level_d = level_q - 2'd1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         level_q    <= '0;
         none_cnt_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         none_cnt_q <= none_cnt_d;
      end
   end

   // Entry storage is deliberately not reset; push is already blocked during rst
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {in_v, in_code};
      end
   end

   assign level    = level_q;
   assign none_cnt = none_cnt_q;

endmodule

// File: tb/tb_dec4_stream.sv
// Directed self-checking bench for dec4_stream: inputs change 1 ns after each rising
// edge, registered outputs are checked at that same point.
module tb_dec4_stream;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [1:0] in_code;
   logic       in_v;
   logic       in_ready;
   logic       out_valid;
   logic [3:0] out_onehot;
   logic       out_ready;
   logic [1:0] level;
   logic [7:0] none_cnt;

   int unsigned pass_cnt = 0;
   int unsigned total_cnt = 0;

   dec4_stream dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_code    (in_code),
      .in_v       (in_v),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_onehot (out_onehot),
      .out_ready  (out_ready),
      .level      (level),
      .none_cnt   (none_cnt)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_code = 2'd0; in_v = 1'b0; out_ready = 1'b0;
      cyc(); cyc();
      total_cnt++; if (level !== 2'd0) $display("FAIL reset_level got %0d exp 0", level); else pass_cnt++;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else pass_cnt++;
      total_cnt++; if (out_onehot !== 4'b0000) $display("FAIL reset_onehot got %b exp 0000", out_onehot); else pass_cnt++;
      total_cnt++; if (none_cnt !== 8'd0) $display("FAIL reset_none_cnt got %0d exp 0", none_cnt); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready_during_rst got %b exp 0", in_ready); else pass_cnt++;
      rst = 1'b0;
      #1;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready_after got %b exp 1", in_ready); else pass_cnt++;
   endtask

   task automatic test_single();
      in_valid = 1'b1; in_v = 1'b1; in_code = 2'd2; out_ready = 1'b0;
      #1;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL single_no_bypass got %b exp 0", out_valid); else pass_cnt++;
      cyc();
      in_valid = 1'b0;
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL single_out_valid got %b exp 1", out_valid); else pass_cnt++;
      total_cnt++; if (out_onehot !== 4'b0100) $display("FAIL single_onehot got %b exp 0100", out_onehot); else pass_cnt++;
      total_cnt++; if (level !== 2'd1) $display("FAIL single_level got %0d exp 1", level); else pass_cnt++;
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      total_cnt++; if (level !== 2'd0) $display("FAIL single_drain_level got %0d exp 0", level); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      in_valid = 1'b1; in_v = 1'b1; in_code = 2'd0; out_ready = 1'b0;
      cyc();
      in_code = 2'd3;
      cyc();
      total_cnt++; if (level !== 2'd2) $display("FAIL b2b_full_level got %0d exp 2", level); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL b2b_full_in_ready got %b exp 0", in_ready); else pass_cnt++;
      total_cnt++; if (out_onehot !== 4'b0001) $display("FAIL b2b_head0 got %b exp 0001", out_onehot); else pass_cnt++;
      in_code = 2'd1;
      cyc();
      total_cnt++; if (level !== 2'd2) $display("FAIL b2b_ignored_push_level got %0d exp 2", level); else pass_cnt++;
      // push attempt while full with a pop in the same cycle must still be dropped
      out_ready = 1'b1;
      cyc();
      in_valid = 1'b0;
      total_cnt++; if (level !== 2'd1) $display("FAIL b2b_full_pushpop_level got %0d exp 1", level); else pass_cnt++;
      total_cnt++; if (out_onehot !== 4'b1000) $display("FAIL b2b_head3 got %b exp 1000", out_onehot); else pass_cnt++;
      cyc();
      out_ready = 1'b0;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL b2b_empty_valid got %b exp 0", out_valid); else pass_cnt++;
      total_cnt++; if (out_onehot !== 4'b0000) $display("FAIL b2b_empty_onehot got %b exp 0000", out_onehot); else pass_cnt++;
      total_cnt++; if (level !== 2'd0) $display("FAIL b2b_empty_level got %0d exp 0", level); else pass_cnt++;
   endtask

   task automatic test_simul();
      in_valid = 1'b1; in_v = 1'b1; in_code = 2'd1; out_ready = 1'b0;
      cyc();
      total_cnt++; if (out_onehot !== 4'b0010) $display("FAIL simul_head1 got %b exp 0010", out_onehot); else pass_cnt++;
      in_code = 2'd2; out_ready = 1'b1;
      cyc();
      in_valid = 1'b0;
      total_cnt++; if (level !== 2'd1) $display("FAIL simul_level got %0d exp 1", level); else pass_cnt++;
      total_cnt++; if (out_onehot !== 4'b0100) $display("FAIL simul_head2 got %b exp 0100", out_onehot); else pass_cnt++;
      cyc();
      total_cnt++; if (level !== 2'd0) $display("FAIL simul_drain_level got %0d exp 0", level); else pass_cnt++;
      cyc();
      out_ready = 1'b0;
      total_cnt++; if (level !== 2'd0) $display("FAIL empty_pop_level got %0d exp 0", level); else pass_cnt++;
      total_cnt++; if (none_cnt !== 8'd0) $display("FAIL simul_none_cnt got %0d exp 0", none_cnt); else pass_cnt++;
   endtask

   task automatic test_saturate();
      int unsigned exp_cnt;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      cyc();
      rst = 1'b0;
      in_valid = 1'b1; in_v = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         in_code = 2'(i);
         cyc();
         exp_cnt = (i > 255) ? 255 : i;
         total_cnt++;
         if (out_valid !== 1'b1 || out_onehot !== 4'b0000 || none_cnt !== 8'(exp_cnt))
            $display("FAIL sat_step%0d got valid=%b onehot=%b cnt=%0d exp valid=1 onehot=0000 cnt=%0d",
                     i, out_valid, out_onehot, none_cnt, exp_cnt);
         else pass_cnt++;
      end
      in_valid = 1'b0;
      cyc();
      total_cnt++; if (none_cnt !== 8'd255) $display("FAIL sat_final_cnt got %0d exp 255", none_cnt); else pass_cnt++;
      total_cnt++; if (level !== 2'd0) $display("FAIL sat_final_level got %0d exp 0", level); else pass_cnt++;
      in_valid = 1'b1; in_v = 1'b1; in_code = 2'd3;
      cyc();
      in_valid = 1'b0;
      total_cnt++; if (out_onehot !== 4'b1000) $display("FAIL sat_v1_onehot got %b exp 1000", out_onehot); else pass_cnt++;
      cyc();
      out_ready = 1'b0;
      total_cnt++; if (none_cnt !== 8'd255) $display("FAIL sat_v1_cnt got %0d exp 255", none_cnt); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      in_valid = 1'b1; in_v = 1'b1; in_code = 2'd1; out_ready = 1'b0;
      cyc(); cyc();
      total_cnt++; if (level !== 2'd2) $display("FAIL rmid_pre_level got %0d exp 2", level); else pass_cnt++;
      rst = 1'b1; out_ready = 1'b1;
      #1;
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL rmid_in_ready_rst got %b exp 0", in_ready); else pass_cnt++;
      cyc();
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      #1;
      total_cnt++; if (level !== 2'd0) $display("FAIL rmid_level got %0d exp 0", level); else pass_cnt++;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL rmid_out_valid got %b exp 0", out_valid); else pass_cnt++;
      total_cnt++; if (none_cnt !== 8'd0) $display("FAIL rmid_none_cnt got %0d exp 0", none_cnt); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL rmid_in_ready got %b exp 1", in_ready); else pass_cnt++;
      total_cnt++; if (out_onehot !== 4'b0000) $display("FAIL rmid_onehot got %b exp 0000", out_onehot); else pass_cnt++;
   endtask

   task automatic test_sweep();
      logic [3:0] exp_tab [8];
      logic [2:0] pair;
      exp_tab = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
      for (int i = 0; i < 8; i++) begin
         pair = 3'(i);
         in_valid = 1'b1; in_v = pair[2]; in_code = pair[1:0]; out_ready = 1'b0;
         cyc();
         in_valid = 1'b0;
         total_cnt++;
         if (out_valid !== 1'b1 || out_onehot !== exp_tab[i])
            $display("FAIL sweep_v%0b_code%0d got valid=%b onehot=%b exp valid=1 onehot=%b",
                     pair[2], pair[1:0], out_valid, out_onehot, exp_tab[i]);
         else pass_cnt++;
         out_ready = 1'b1;
         cyc();
         out_ready = 1'b0;
      end
      total_cnt++; if (none_cnt !== 8'd4) $display("FAIL sweep_none_cnt got %0d exp 4", none_cnt); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_simul();
      test_saturate();
      test_reset_mid();
      test_sweep();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/dec4_stream.md
DEC4_STREAM -- requirements
Module: dec4_stream

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 in_valid  input  1  producer offers a code word this cycle.
REQ-004 in_code  input  2  encoded line index (0..3), as produced by the 4-to-2 priority encoder.
REQ-005 in_v  input  1  encoder "any input active" flag; 0 = no line active, in_code ignored.
REQ-006 in_ready  output  1  block can accept a word this cycle.
REQ-007 out_valid  output  1  out_onehot holds a decoded word.
REQ-008 out_onehot  output  4  decoded one-hot line vector.
REQ-009 out_ready  input  1  consumer takes the word this cycle.
REQ-010 level  output  2  current buffer occupancy, 0..2.
REQ-011 none_cnt  output  8  count of popped words with in_v=0, saturating.

Function
REQ-012 Storage SHALL be a 2-entry FIFO; each entry holds {v, code} (3 bits).
REQ-013 Push SHALL occur on a rising edge where in_valid=1 and in_ready=1; other in_valid cycles have no effect.
REQ-014 in_ready SHALL equal (rst=0) and (level!=2); no combinational path from out_ready to in_ready.
REQ-015 out_valid SHALL equal (level!=0).
REQ-016 Pop SHALL occur on a rising edge where out_valid=1 and out_ready=1.
REQ-017 Decode of head entry: v=1 -> out_onehot = 1 << code (0->0001, 1->0010, 2->0100, 3->1000); v=0 -> 0000.
REQ-018 out_onehot SHALL be 0000 whenever out_valid=0.
REQ-019 Latency: a word pushed into an empty FIFO SHALL appear on out_onehot with out_valid=1 on the next cycle; no same-cycle bypass.
REQ-020 Ordering SHALL be strict FIFO; words are never dropped or duplicated.
REQ-021 level SHALL update: +1 on push only, -1 on pop only, unchanged on push+pop or neither.
REQ-022 Simultaneous push and pop at level=1: head pops, new word becomes head next cycle, level stays 1.
REQ-023 Full (level=2): in_ready=0; push attempts ignored even if a pop occurs that cycle.
REQ-024 Empty (level=0): out_ready ignored; no pop, level stays 0.
REQ-025 none_cnt SHALL increment by 1 on each pop whose head entry has v=0; at 255 it SHALL hold 255.
REQ-026 Pops with v=1 SHALL not change none_cnt.

Reset
REQ-027 While rst=1 at a rising edge: level=0, FIFO emptied, none_cnt=0, out_valid=0, out_onehot=0000.
REQ-028 in_ready SHALL be 0 in any cycle where rst=1; push and pop in that cycle are discarded.
REQ-029 Reset mid-operation SHALL discard buffered words; first cycle after rst deasserts: in_ready=1, out_valid=0.
REQ-030 FIFO entry contents need not be cleared; only pointers/level and counter are reset.

Verification
REQ-031 Reset then push {v=1,code=2} with out_ready=0 -> next cycle out_valid=1, out_onehot=0100, level=1.
REQ-032 Push codes 0,3 back-to-back, out_ready=0 -> level=2, in_ready=0; third push (code 1) ignored; then out_ready=1 -> outputs 0001 then 1000, then out_valid=0.
REQ-033 Level=1 (head code 1), push code 2 with out_ready=1 same cycle -> 0010 popped, next cycle out_onehot=0100, level=1.
REQ-034 Push 300 words with v=0, out_ready=1 continuously -> each shows out_onehot=0000 with out_valid=1; none_cnt ends at 255; push v=1 word -> none_cnt stays 255.
REQ-035 Level=2, assert rst one cycle with in_valid=1 and out_ready=1 -> next cycle level=0, out_valid=0, none_cnt=0, in_ready=1.
REQ-036 Exhaustive sweep of all 8 {v,code} pairs -> out_onehot matches REQ-017 for each.
